// File: rtl/load_vector_pkg.sv
// Shared types and helpers for the DRAM-to-vector-buffer loader.
// Tile geometry here matches the default 256-bit tile of 8-bit elements.
package load_vector_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DRAIN   = 3'd2,
      S_WRITE   = 3'd3,
      S_ADVANCE = 3'd4,
      S_FINISH  = 3'd5
   } ld_state_t;

   localparam int LV_TILE_ELEMS = 32;
   localparam int IDX_W         = $clog2(LV_TILE_ELEMS);

   localparam logic [10:0]    TILE_ELEMS_REM = 11'(LV_TILE_ELEMS);
   localparam logic [IDX_W:0] TILE_CNT_FULL  = (IDX_W+1)'(LV_TILE_ELEMS);

   // Elements carried by the next tile: a full tile or whatever is left.
   function automatic logic [IDX_W:0] tile_count(input logic [10:0] rem);
      logic [IDX_W:0] cnt;
      if (rem >= TILE_ELEMS_REM) begin
         cnt = TILE_CNT_FULL;
      end else begin
         cnt = rem[IDX_W:0];
      end
      return cnt;
   endfunction

endpackage

// File: rtl/rd_latency_tracker.sv
// Follows each accepted DRAM read through the memory pipeline so the
// returning byte can be steered to its tile slot.
module rd_latency_tracker #(
   parameter int LATENCY = 1,
   parameter int IDX_W   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [IDX_W-1:0] push_idx,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic             empty
);

   logic [LATENCY-1:0] valid_r;
   logic [IDX_W-1:0]   idx_r [LATENCY];
   logic               pending_s;

   // Shift register of {valid, idx}; stage LATENCY-1 lines up with mem_rdata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            idx_r[i] <= '0;
         end
      end else begin
         valid_r[0] <= push;
         idx_r[0]   <= push_idx;
         for (int i = 1; i < LATENCY; i++) begin
            valid_r[i] <= valid_r[i-1];
            idx_r[i]   <= idx_r[i-1];
         end
      end
   end

   // Empty once nothing is in flight beyond the stage retiring on this edge.
   always_comb begin
      pending_s = push;
      for (int i = 0; i < LATENCY - 1; i++) begin
         pending_s = pending_s | valid_r[i];
      end
   end

   assign out_valid = valid_r[LATENCY-1];
   assign out_idx   = idx_r[LATENCY-1];
   assign empty     = ~pending_s;

endmodule

// File: rtl/load_vector.sv
// Loads `length` consecutive DRAM bytes into zero-padded tiles and writes
// each tile to vector buffer `buf_id`, one acknowledged tile at a time.
module load_vector
   import load_vector_pkg::*;
#(
   parameter int ADDR_WIDTH  = 24,
   parameter int DATA_WIDTH  = 8,
   parameter int TILE_WIDTH  = 256,
   parameter int TILE_ELEMS  = TILE_WIDTH / DATA_WIDTH,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] dram_addr,
   input  logic [9:0]            length,
   input  logic [4:0]            buf_id,
   output logic                  mem_re,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  buf_write_en,
   output logic [4:0]            buf_write_id,
   output logic [DATA_WIDTH-1:0] buf_write_data [0:TILE_ELEMS-1],
   input  logic                  buf_write_done,
   output logic                  busy,
   output logic                  done
);

   localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

   ld_state_t             state_r;
   ld_state_t             state_next_s;
   logic [ADDR_WIDTH-1:0] base_addr_r;
   logic [10:0]           remaining_r;
   logic [IDX_W-1:0]      issue_idx_r;
   logic [IDX_W-1:0]      req_idx_r;
   logic [IDX_W:0]        tile_cnt_r;
   logic [DATA_WIDTH-1:0] tile_r [0:TILE_ELEMS-1];
   logic                  mem_re_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic                  buf_write_en_r;
   logic                  busy_r;
   logic                  done_r;

   logic                  launch_s;
   logic                  init_s;
   logic                  issue_s;
   logic                  ack_s;
   logic                  capture_s;
   logic                  last_issue_s;
   logic [10:0]           tile_src_s;
   logic                  trk_valid_s;
   logic [IDX_W-1:0]      trk_idx_s;
   logic                  trk_empty_s;

   // The tracker sees a request on the edge the memory samples mem_re.
   rd_latency_tracker #(
      .LATENCY (MEM_LATENCY),
      .IDX_W   (IDX_W)
   ) u_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (mem_re_r),
      .push_idx  (req_idx_r),
      .out_valid (trk_valid_s),
      .out_idx   (trk_idx_s),
      .empty     (trk_empty_s)
   );

   assign last_issue_s = ({1'b0, issue_idx_r} == (tile_cnt_r - CNT_ONE));
   assign capture_s    = trk_valid_s && ((state_r == S_FETCH) || (state_r == S_DRAIN));

   // Next-state and per-cycle control decode.
   always_comb begin
      state_next_s = state_r;
      launch_s     = 1'b0;
      init_s       = 1'b0;
      issue_s      = 1'b0;
      ack_s        = 1'b0;
      tile_src_s   = remaining_r;
      case (state_r)
         S_IDLE: begin
            tile_src_s = {1'b0, length};
            if (start) begin
               launch_s = 1'b1;
               if (length == 10'd0) begin
                  state_next_s = S_FINISH;
               end else begin
                  state_next_s = S_FETCH;
                  init_s       = 1'b1;
               end
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_FETCH: begin
            issue_s = 1'b1;
            if (last_issue_s) begin
               state_next_s = S_DRAIN;
            end else begin
               state_next_s = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (trk_empty_s) begin
               state_next_s = S_WRITE;
            end else begin
               state_next_s = S_DRAIN;
            end
         end
         S_WRITE: begin
            if (buf_write_done) begin
               ack_s        = 1'b1;
               state_next_s = S_ADVANCE;
            end else begin
               state_next_s = S_WRITE;
            end
         end
         S_ADVANCE: begin
            if (remaining_r != 11'd0) begin
               state_next_s = S_FETCH;
               init_s       = 1'b1;
            end else begin
               state_next_s = S_FINISH;
            end
         end
         S_FINISH: begin
            state_next_s = S_IDLE;
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   // State, counters, read issue and tile capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= S_IDLE;
         base_addr_r    <= '0;
         remaining_r    <= 11'd0;
         issue_idx_r    <= '0;
         req_idx_r      <= '0;
         tile_cnt_r     <= '0;
         mem_re_r       <= 1'b0;
         mem_addr_r     <= '0;
         buf_write_en_r <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         for (int i = 0; i < TILE_ELEMS; i++) begin
            tile_r[i] <= '0;
         end
      end else begin
         state_r        <= state_next_s;
         busy_r         <= (state_next_s != S_IDLE);
         done_r         <= (state_r == S_FINISH);
         buf_write_en_r <= (state_next_s == S_WRITE);
         mem_re_r       <= issue_s;

         if (issue_s) begin
            mem_addr_r  <= base_addr_r + ADDR_WIDTH'(issue_idx_r);
            req_idx_r   <= issue_idx_r;
            issue_idx_r <= issue_idx_r + 1'b1;
         end

         if (launch_s) begin
            base_addr_r <= dram_addr;
            remaining_r <= {1'b0, length};
         end else if (ack_s) begin
            base_addr_r <= base_addr_r + ADDR_WIDTH'(TILE_ELEMS);
            remaining_r <= remaining_r - 11'(tile_cnt_r);
         end

         // Slots past tile_cnt are never captured, so they stay zero.
         if (init_s) begin
            issue_idx_r <= '0;
            tile_cnt_r  <= tile_count(tile_src_s);
            for (int i = 0; i < TILE_ELEMS; i++) begin
               tile_r[i] <= '0;
            end
         end else if (capture_s) begin
            tile_r[trk_idx_s] <= mem_rdata;
         end
      end
   end

   assign mem_re         = mem_re_r;
   assign mem_addr       = mem_addr_r;
   assign buf_write_en   = buf_write_en_r;
   assign buf_write_id   = buf_id;
   assign buf_write_data = tile_r;
   assign busy           = busy_r;
   assign done           = done_r;

endmodule

// File: tb/tb_load_vector.sv
// Scoreboard bench for load_vector: one DUT at MEM_LATENCY=1, one at 3,
// sharing command inputs and the buffer-file acknowledge.
module tb_load_vector;

   localparam int AW = 24;
   localparam int DW = 8;
   localparam int TE = 32;

   typedef struct packed {
      logic [4:0]   id;
      logic [255:0] data;
   } tile_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start1 = 1'b0;
   logic          start3 = 1'b0;
   logic [AW-1:0] dram_addr = '0;
   logic [9:0]    length = '0;
   logic [4:0]    buf_id = '0;
   logic          bwd = 1'b0;

   logic          re1, re3, bwe1, bwe3, busy1, busy3, done1, done3;
   logic [AW-1:0] ma1, ma3;
   logic [4:0]    bid1, bid3;
   logic [DW-1:0] bd1 [0:TE-1];
   logic [DW-1:0] bd3 [0:TE-1];
   logic [DW-1:0] rd1;
   logic [DW-1:0] p3 [3];

   addr_q_t_dummy_guard_unused_never u_never ();

   load_vector #(.MEM_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dram_addr(dram_addr),
      .length(length), .buf_id(buf_id), .mem_re(re1), .mem_addr(ma1),
      .mem_rdata(rd1), .buf_write_en(bwe1), .buf_write_id(bid1),
      .buf_write_data(bd1), .buf_write_done(bwd), .busy(busy1), .done(done1)
   );

   load_vector #(.MEM_LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .dram_addr(dram_addr),
      .length(length), .buf_id(buf_id), .mem_re(re3), .mem_addr(ma3),
      .mem_rdata(p3[2]), .buf_write_en(bwe3), .buf_write_id(bid3),
      .buf_write_data(bd3), .buf_write_done(bwd), .busy(busy3), .done(done3)
   );

   logic [AW-1:0] addr_q [$];
   tile_t         tile_q [$];
   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt1 = 0;
   int done_cnt3 = 0;
   int exp_done1 = 0;
   int exp_done3 = 0;
   int ack_wait = 1;

   function automatic logic [7:0] dram(input logic [AW-1:0] a);
      return a[7:0] ^ (a[15:8] - 8'd1);
   endfunction

   function automatic logic [255:0] pack(input logic [7:0] d [0:31]);
      logic [255:0] p;
      for (int i = 0; i < TE; i++) p[i*8 +: 8] = d[i];
      return p;
   endfunction

   task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // DRAM models; idle cycles return junk that must never be captured.
   always @(posedge clk) begin
      rd1   <= re1 ? dram(ma1) : 8'hEE;
      p3[0] <= re3 ? dram(ma3) : 8'hEE;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end

   initial forever begin
      @(posedge done1);
      done_cnt1++;
   end

   initial forever begin
      @(posedge done3);
      done_cnt3++;
   end

   // Monitor: every read address and every new tile write against the queues.
   initial begin
      logic pb1, pb3;
      pb1 = 1'b0;
      pb3 = 1'b0;
      forever begin
         @(negedge clk);
         if (re1 || re3) begin
            if (addr_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_mem_re: got addr %h expected none", re1 ? ma1 : ma3);
            end else begin
               chk("mem_addr", re1 ? ma1 : ma3, addr_q.pop_front());
            end
         end
         if ((bwe1 && !pb1) || (bwe3 && !pb3)) begin
            tile_t act;
            act.id   = bwe1 ? bid1 : bid3;
            act.data = bwe1 ? pack(bd1) : pack(bd3);
            if (tile_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_tile: got %h expected none", act);
            end else begin
               chk("tile", act, tile_q.pop_front());
            end
         end
         pb1 = bwe1;
         pb3 = bwe3;
      end
   end

   // Buffer-file responder: holds off ack_wait cycles, checking the request is steady.
   initial forever begin
      @(negedge clk);
      if ((bwe1 || bwe3) && !bwd) begin
         logic [255:0] snap;
         snap = bwe1 ? pack(bd1) : pack(bd3);
         for (int k = 0; k < ack_wait; k++) begin
            @(negedge clk);
            chk("bwe_held", bwe1 | bwe3, 1'b1);
            chk("data_stable", bwe1 ? pack(bd1) : pack(bd3), snap);
            chk("no_re_in_write", re1 | re3, 1'b0);
         end
         bwd = 1'b1;
         @(negedge clk);
         bwd = 1'b0;
      end
   end

   task automatic issue(input int inst, input logic [AW-1:0] a, input int len, input logic [4:0] id);
      for (int i = 0; i < len; i++) addr_q.push_back(a + AW'(i));
      for (int t = 0; t * TE < len; t++) begin
         tile_t e;
         e.id   = id;
         e.data = '0;
         for (int i = 0; i < TE; i++) begin
            if (t * TE + i < len) e.data[i*8 +: 8] = dram(a + AW'(t * TE + i));
         end
         tile_q.push_back(e);
      end
      dram_addr = a;
      length    = 10'(len);
      buf_id    = id;
      if (inst == 1) start1 = 1'b1;
      else start3 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic wait_done(input int inst);
      if (inst == 1) exp_done1++;
      else exp_done3++;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ((inst == 1 && done_cnt1 >= exp_done1) || (inst == 3 && done_cnt3 >= exp_done3)) break;
      end
      repeat (4) @(negedge clk);
      if (inst == 1) chk("done_count1", done_cnt1, exp_done1);
      else chk("done_count3", done_cnt3, exp_done3);
      chk("addr_q_drained", addr_q.size(), 0);
      chk("tile_q_drained", tile_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_mem_re", re1, 1'b0);
      chk("rst_bwe", bwe1, 1'b0);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_done", done1, 1'b0);
      chk("rst_mem_addr", ma1, 24'h0);
      chk("rst_tile", pack(bd1), 256'h0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1, 24'h000100, 32, 5'd3);
      wait_done(1);

      issue(1, 24'h000200, 40, 5'd7);
      wait_done(1);

      dram_addr = 24'h000300;
      length    = 10'd0;
      start1    = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("len0_busy", busy1, 1'b1);
      chk("len0_done_early", done1, 1'b0);
      @(negedge clk);
      chk("len0_done", done1, 1'b1);
      chk("len0_busy_drop", busy1, 1'b0);
      exp_done1++;
      repeat (4) @(negedge clk);
      chk("len0_done_count", done_cnt1, exp_done1);

      ack_wait = 5;
      issue(1, 24'h000400, 10, 5'd9);
      wait_done(1);
      ack_wait = 1;

      issue(3, 24'h000500, 5, 5'd2);
      wait_done(3);

      issue(1, 24'hFFFFF0, 40, 5'd4);
      wait_done(1);

      issue(1, 24'h000600, 40, 5'd4);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_mem_re", re1, 1'b0);
      chk("midrst_mem_addr", ma1, 24'h0);
      chk("midrst_busy", busy1, 1'b0);
      chk("midrst_bwe", bwe1, 1'b0);
      chk("midrst_tile", pack(bd1), 256'h0);
      addr_q.delete();
      tile_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1, 24'h0006F0, 1, 5'd6);
      wait_done(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

module addr_q_t_dummy_guard_unused_never;
endmodule

// File: doc/load_vector.md
Name: load_vector

Overview:
- DRAM-to-vector-buffer loader; the read-direction counterpart of the vector store unit.
- On `start`, reads `length` consecutive bytes from DRAM at `dram_addr` and packs them into TILE_ELEMS-wide tiles. Elements past `length` in the last tile are zero.
- Each tile is written into vector buffer `buf_id` over the shared buffer-file write port; the next tile is not fetched until the buffer file acknowledges.
- Sits between the instruction dispatcher and the vector buffer file.

Parameters:
- ADDR_WIDTH, 24, DRAM byte-address width
- DATA_WIDTH, 8, element width in bits
- TILE_WIDTH, 256, tile width in bits
- TILE_ELEMS, TILE_WIDTH/DATA_WIDTH, elements per tile (32)
- MEM_LATENCY, 1, cycles from `mem_re` sampled high to matching `mem_rdata` valid (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch pulse; sampled only in S_IDLE
- dram_addr  in  ADDR_WIDTH  first byte address
- length  in  10  number of elements to load (0..1023)
- buf_id  in  5  destination vector buffer
- mem_re  out  1  DRAM read strobe (registered)
- mem_addr  out  ADDR_WIDTH  DRAM read address (registered)
- mem_rdata  in  DATA_WIDTH  DRAM read data, valid MEM_LATENCY cycles after `mem_re`
- buf_write_en  out  1  tile write request, held until acknowledged
- buf_write_id  out  5  constant copy of `buf_id`
- buf_write_data  out  DATA_WIDTH x [0:TILE_ELEMS-1]  packed tile
- buf_write_done  in  1  one-cycle buffer-file acknowledge
- busy  out  1  high in every state except S_IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, `rst_n`=0):
  - state=S_IDLE.
  - `mem_re`, `buf_write_en`, `done`, `busy` = 0.
  - `mem_addr` = 0; tile register all zero; all counters zero.
  - In-flight reads are discarded. Reset mid-operation abandons the transfer with no `done` pulse.
- Latched in S_IDLE on `start`: `base_addr`=`dram_addr`, `remaining`=`length` (11-bit, element units). `buf_id` is used directly and must stay stable while busy.
- `start` while busy: ignored.
- States:
  - S_IDLE:
    - `start` & `length`==0 -> S_FINISH.
    - `start` & `length`!=0 -> S_FETCH. Also clear the tile register, set issue_idx=0, `tile_cnt`=min(TILE_ELEMS, `remaining`).
  - S_FETCH:
    - Each cycle: `mem_re`<=1, `mem_addr`<=`base_addr`+issue_idx, and push issue_idx into the latency tracker; issue_idx++.
    - After issuing index `tile_cnt`-1 -> S_DRAIN.
  - S_DRAIN:
    - `mem_re`=0. Wait until the tracker reports no outstanding reads -> S_WRITE.
  - Capture (runs in S_FETCH and S_DRAIN):
    - When the tracker's output valid is high, write `mem_rdata` into tile[returned idx].
    - Indices >= `tile_cnt` are never written, so they stay 0.
  - S_WRITE:
    - Hold `buf_write_en`=1 with stable `buf_write_data`.
    - On `buf_write_done` (sampled on the same edge): `buf_write_en`<=0, `remaining`-=`tile_cnt`, `base_addr`+=TILE_ELEMS -> S_ADVANCE.
  - S_ADVANCE:
    - `remaining`!=0 -> S_FETCH, with tile cleared, issue_idx=0 and `tile_cnt` recomputed.
    - Otherwise -> S_FINISH.
  - S_FINISH: `done`<=1 for one cycle -> S_IDLE. `busy` drops in the same cycle `done` is high.
- Latency, full 32-element tile with immediate ack:
  - 32 issue cycles + MEM_LATENCY+1 drain + 1 write + 1 advance.
  - For the final tile, `done` follows S_ADVANCE by one further cycle.
- Arithmetic:
  - `mem_addr` and `base_addr` wrap modulo 2^ADDR_WIDTH; no overflow flag.
  - Counters are in element units; no bit-count arithmetic.
- `buf_write_done` outside S_WRITE: ignored.
- `mem_rdata` that arrives with no tracked request: ignored.

Decomposition:
- Package `load_vector_pkg`: state enum `ld_state_t` (S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_ADVANCE, S_FINISH) and localparam IDX_W=$clog2(TILE_ELEMS).
- Sub-module `rd_latency_tracker`:
  - MEM_LATENCY-deep shift register of {valid, idx}.
  - Inputs: push, push_idx.
  - Outputs: out_valid, out_idx, empty.
  - Reset by `rst_n`.

Test Plan:
- `length`=32, `dram_addr`=0x000100, DRAM[0x100+i]=i, ack 1 cycle after `buf_write_en` -> one tile write with data[i]=i; `done` once; 32 `mem_re` pulses, addresses 0x100..0x11F.
- `length`=40, `dram_addr`=0x000200 -> two tile writes. Second tile: data[0..7]=DRAM[0x220..0x227], data[8..31]=0; second tile's first `mem_addr`=0x220.
- `length`=0 -> no `mem_re`, no `buf_write_en`; `done` pulses 2 cycles after `start`.
- `buf_write_done` delayed 5 cycles -> `buf_write_en` and data held stable for those 5 cycles; no `mem_re` during the wait.
- MEM_LATENCY=3, `length`=5 -> data[0..4] correct, data[5..31]=0; S_DRAIN lasts until the tracker is empty.
- `rst_n` asserted mid-S_FETCH -> all outputs at reset values immediately. A new `start` with `length`=1 after release completes cleanly with no stale data.
